// File: rtl/weight_ram_ctrl.sv
// weight_ram_ctrl: controller on the reader side of the single-port weight RAM.
// It fills the RAM with LFSR-derived signed initial weights. It then streams
// address bursts out over a valid/ready channel. A 2-entry skid FIFO sits behind
// a bypass path, so a word can be offered in the same cycle that ram_q is valid.
// Optional build macro: WEIGHT_SCALE_EN applies an arithmetic >>>2 to each
// initial weight.
module weight_ram_ctrl #(
  parameter int          DATA_W = 10,
  parameter int          ADDR_W = 7,
  parameter int          DEPTH  = 128,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic              Clock,
  input  logic              Rst,
  input  logic              init_start,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W:0]   rd_len,
  output logic              busy,
  output logic              init_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_d,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [DATA_W-1:0] w_data,
  output logic              w_last
);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_READ, S_DRAIN} state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [DATA_W-1:0] weight_of(input logic [DATA_W-1:0] v);
`ifdef WEIGHT_SCALE_EN
    logic signed [DATA_W-1:0] s;
    s = v;
    return s >>> 2;
`else
    return v;
`endif
  endfunction

  state_t            state;
  logic [15:0]       lfsr;
  logic [ADDR_W:0]   rd_left;    // reads still to issue
  logic [ADDR_W:0]   out_left;   // words still to deliver
  logic              addr_vld;   // a read address is on ram_addr this cycle
  logic              q_vld;      // ram_q holds the data for an issued read
  logic [DATA_W-1:0] fifo_mem [2];
  logic              fifo_rd;
  logic              fifo_wr;
  logic [1:0]        fifo_cnt;

  logic              pop;
  logic              fifo_push;
  logic              fifo_pop;
  logic [2:0]        pipe_cnt;
  logic              can_issue;
  logic [ADDR_W-1:0] addr_inc;

  assign busy    = (state != S_IDLE);
  assign w_valid = (fifo_cnt != 2'd0) | q_vld;
  assign w_last  = w_valid & (out_left == (ADDR_W+1)'(1));
  assign pop     = w_valid & w_ready;

  // Output mux: the FIFO head when it holds data, else bypass ram_q; zero when idle.
  // NOTE: always_comb gives every output a default first, so no latch can be inferred.
  always_comb begin
    w_data = '0;
    if (fifo_cnt != 2'd0) w_data = fifo_mem[fifo_rd];
    else if (q_vld)       w_data = ram_q;
  end

  // Issue control: count words held plus reads that will land, allowing for this cycle's pop.
  always_comb begin
    fifo_pop  = pop & (fifo_cnt != 2'd0);
    fifo_push = q_vld & ~((fifo_cnt == 2'd0) & pop);
    pipe_cnt  = 3'(fifo_cnt) + 3'(q_vld) + 3'(addr_vld) - 3'(pop);
    can_issue = (pipe_cnt < 3'd2) && (rd_left != '0);
    addr_inc  = (ram_addr == ADDR_W'(DEPTH-1)) ? '0 : ram_addr + 1'b1;
  end

  // Main FSM: drives the registered RAM pins and keeps the burst counters.
  // NOTE: use non-blocking assignments in clocked blocks, so every register updates from pre-edge values.
  always_ff @(posedge Clock) begin
    if (Rst) begin
      state     <= S_IDLE;
      lfsr      <= SEED;
      init_done <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_d     <= '0;
      addr_vld  <= 1'b0;
      rd_left   <= '0;
      out_left  <= '0;
    end else begin
      if (pop) out_left <= out_left - 1'b1;
      case (state)
        S_IDLE: begin
          if (init_start) begin
            state     <= S_INIT;
            init_done <= 1'b0;
            ram_we    <= 1'b1;
            ram_addr  <= '0;
            ram_d     <= weight_of(SEED[DATA_W-1:0]);
            lfsr      <= lfsr_next(SEED);
          end else if (rd_start && rd_len != '0) begin
            state    <= S_READ;
            ram_addr <= rd_base;
            addr_vld <= 1'b1;
            rd_left  <= rd_len - 1'b1;
            out_left <= rd_len;
          end
        end
        S_INIT: begin
          if (ram_addr == ADDR_W'(DEPTH-1)) begin
            state     <= S_IDLE;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_d     <= '0;
            init_done <= 1'b1;
          end else begin
            ram_addr <= addr_inc;
            ram_d    <= weight_of(lfsr[DATA_W-1:0]);
            lfsr     <= lfsr_next(lfsr);
          end
        end
        S_READ: begin
          if (rd_left == '0) begin
            state    <= S_DRAIN;
            ram_addr <= '0;
            addr_vld <= 1'b0;
          end else if (can_issue) begin
            ram_addr <= addr_inc;
            addr_vld <= 1'b1;
            rd_left  <= rd_left - 1'b1;
          end else begin
            addr_vld <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (out_left == '0) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read-return tracking and FIFO pointers.
  always_ff @(posedge Clock) begin
    if (Rst) begin
      q_vld    <= 1'b0;
      fifo_rd  <= 1'b0;
      fifo_wr  <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      q_vld <= addr_vld;
      if (fifo_push) fifo_wr <= ~fifo_wr;
      if (fifo_pop)  fifo_rd <= ~fifo_rd;
      fifo_cnt <= fifo_cnt + 2'(fifo_push) - 2'(fifo_pop);
    end
  end

  // FIFO storage.
  // NOTE: the data array is not reset, because fifo_cnt alone decides which entries are valid.
  always_ff @(posedge Clock) begin
    if (fifo_push) fifo_mem[fifo_wr] <= ram_q;
  end

endmodule

// File: tb/tb_weight_ram_ctrl.sv
// Testbench for weight_ram_ctrl, with a behavioural single-port RAM and a weight/burst reference model.
module tb_weight_ram_ctrl;
  localparam int DATA_W = 10;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;
  localparam logic [15:0] SEED = 16'hACE1;

  logic              Clock = 1'b0;
  logic              Rst;
  logic              init_start, rd_start, w_ready;
  logic [ADDR_W-1:0] rd_base;
  logic [ADDR_W:0]   rd_len;
  logic              busy, init_done, ram_we, w_valid, w_last;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_d, ram_q, w_data;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] ram_mem   [DEPTH];
  logic [DATA_W-1:0] model_mem [DEPTH];

  weight_ram_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .SEED(SEED)) dut (
    .Clock(Clock), .Rst(Rst), .init_start(init_start), .rd_start(rd_start),
    .rd_base(rd_base), .rd_len(rd_len), .busy(busy), .init_done(init_done),
    .ram_addr(ram_addr), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last)
  );

  always #5 Clock = ~Clock;

  // Single-port RAM with synchronous write and a registered read.
  always @(posedge Clock) begin
    if (ram_we) ram_mem[ram_addr] <= ram_d;
    ram_q <= ram_mem[ram_addr];
  end

  // Expected initial contents: step the Galois LFSR once per word.
  function automatic void build_model();
    logic [15:0] l;
    int s;
    l = SEED;
    for (int i = 0; i < DEPTH; i++) begin
      s = int'(l[DATA_W-1:0]);
`ifdef WEIGHT_SCALE_EN
      if (s >= 512) s = s - 1024;
      s = s >>> 2;
`endif
      model_mem[i] = DATA_W'(s);
      l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    end
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, init_done, ram_we, w_valid, w_last} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000", {busy, init_done, ram_we, w_valid, w_last});
    end
    checks++;
    if ({ram_addr, ram_d, w_data} !== '0) begin
      errors++;
      $display("FAIL reset_buses: addr %h d %h w_data %h expected all 0", ram_addr, ram_d, w_data);
    end
    Rst = 1'b0;
    tick();
  endtask

  // Drive one init_start pulse and check all DEPTH writes plus the completion flag.
  task automatic run_init(input string tag);
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== ADDR_W'(i) || ram_d !== model_mem[i] || busy !== 1'b1 || init_done !== 1'b0 || w_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s_write%0d: we %b addr %0d d %h busy %b done %b wv %b expected we 1 addr %0d d %h busy 1 done 0 wv 0",
                 tag, i, ram_we, ram_addr, ram_d, busy, init_done, w_valid, i, model_mem[i]);
      end
      tick();
    end
    checks++;
    if (ram_we !== 1'b0 || init_done !== 1'b1 || busy !== 1'b0 || ram_addr !== '0 || ram_d !== '0) begin
      errors++;
      $display("FAIL %s_done: we %b done %b busy %b addr %h d %h expected we 0 done 1 busy 0 addr 0 d 0",
               tag, ram_we, init_done, busy, ram_addr, ram_d);
    end
  endtask

  task automatic test_init();
    run_init("init");
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (ram_mem[i] !== model_mem[i]) begin
        errors++;
        $display("FAIL init_ram%0d: got %h expected %h", i, ram_mem[i], model_mem[i]);
      end
    end
  endtask

  // Read-burst scenarios. mode 0: w_ready held high. mode 1: w_ready low for 5 cycles after the first word. mode 2: random w_ready.
  task automatic run_burst(input int base, input int len, input int mode, input string tag);
    int idx = 0;
    int cyc = 1;
    int first_cyc = -1;
    int last_cyc = -1;
    int stall_left = 0;
    bit stalled = 0;
    bit done = 0;
    logic [DATA_W-1:0] hold_data;
    logic hold_last;
    hold_data = '0;
    hold_last = 1'b0;
    rd_base  = ADDR_W'(base);
    rd_len   = (ADDR_W+1)'(len);
    rd_start = 1'b1;
    w_ready  = 1'b1;
    tick();
    rd_start = 1'b0;
    while (!done && cyc < 2000) begin
      case (mode)
        0:       w_ready = 1'b1;
        1:       w_ready = (stall_left > 0) ? 1'b0 : 1'b1;
        default: w_ready = 1'($urandom_range(0, 1));
      endcase
      if (w_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        checks++;
        if (idx >= len) begin
          errors++;
          $display("FAIL %s_extra: word %h offered after %0d words, expected none", tag, w_data, len);
        end else if (w_data !== model_mem[(base + idx) % DEPTH] || w_last !== (idx == len - 1)) begin
          errors++;
          $display("FAIL %s_word%0d: data %h last %b expected data %h last %b",
                   tag, idx, w_data, w_last, model_mem[(base + idx) % DEPTH], (idx == len - 1));
        end
        if (stalled) begin
          checks++;
          if (w_data !== hold_data || w_last !== hold_last) begin
            errors++;
            $display("FAIL %s_stable%0d: data %h last %b expected held %h %b", tag, idx, w_data, w_last, hold_data, hold_last);
          end
        end
      end else if (stalled) begin
        checks++;
        errors++;
        $display("FAIL %s_drop%0d: w_valid 0 while stalled expected 1", tag, idx);
      end
      stalled   = w_valid && !w_ready;
      hold_data = w_data;
      hold_last = w_last;
      if (!w_ready && stall_left > 0) stall_left--;
      if (w_valid && w_ready) begin
        if (idx == 0 && mode == 1) stall_left = 5;
        last_cyc = cyc;
        idx++;
      end
      if (idx >= len && !busy && !w_valid) done = 1;
      tick();
      cyc++;
    end
    checks++;
    if (!done || idx != len) begin
      errors++;
      $display("FAIL %s_count: delivered %0d words (finished %0d) expected %0d", tag, idx, done, len);
    end
    if (mode == 0) begin
      checks++;
      if (first_cyc != 2 || last_cyc - first_cyc != len - 1) begin
        errors++;
        $display("FAIL %s_timing: first valid cycle %0d span %0d expected 2 and %0d", tag, first_cyc, last_cyc - first_cyc, len - 1);
      end
    end
    tick();
    checks++;
    if (w_valid !== 1'b0 || busy !== 1'b0 || ram_we !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: w_valid %b busy %b we %b expected 0 0 0", tag, w_valid, busy, ram_we);
    end
  endtask

  task automatic test_wrap_burst();
    run_burst(126, 4, 0, "wrap");
  endtask

  task automatic test_stall();
    run_burst(126, 4, 1, "stall");
  endtask

  task automatic test_random_bursts();
    for (int n = 0; n < 8; n++) begin
      run_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, DEPTH)), (n == 0) ? 0 : 2, $sformatf("rand%0d", n));
    end
    run_burst(5, DEPTH, 2, "full");
    run_burst(17, 1, 0, "single");
  endtask

  task automatic test_zero_len();
    rd_base  = 7'd10;
    rd_len   = '0;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (w_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL zero_len%0d: w_valid %b busy %b expected 0 0", i, w_valid, busy);
      end
      tick();
    end
  endtask

  task automatic test_collision();
    rd_base  = 7'd3;
    rd_len   = 8'd4;
    rd_start = 1'b1;
    run_init("collide");
    rd_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (w_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL collide_noread%0d: w_valid %b busy %b expected 0 0", i, w_valid, busy);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_init();
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    checks++;
    if (ram_addr !== 7'd50 || ram_we !== 1'b1) begin
      errors++;
      $display("FAIL midinit_addr: addr %0d we %b expected 50 1", ram_addr, ram_we);
    end
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    checks++;
    if (ram_we !== 1'b0 || busy !== 1'b0 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL midinit_reset: we %b busy %b done %b expected 0 0 0", ram_we, busy, init_done);
    end
    run_init("reinit");
  endtask

  task automatic test_reset_mid_burst();
    rd_base  = 7'd40;
    rd_len   = 8'd20;
    rd_start = 1'b1;
    w_ready  = 1'b0;
    tick();
    rd_start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (w_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midburst_active: w_valid %b busy %b expected 1 1", w_valid, busy);
    end
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    checks++;
    if (w_valid !== 1'b0 || busy !== 1'b0 || w_data !== '0 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL midburst_reset: w_valid %b busy %b w_data %h done %b expected 0 0 0 0", w_valid, busy, w_data, init_done);
    end
    tick();
    run_burst(60, 6, 0, "after_reset");
  endtask

  initial begin
    Rst = 1'b1;
    init_start = 1'b0;
    rd_start = 1'b0;
    w_ready = 1'b0;
    rd_base = '0;
    rd_len = '0;
    for (int i = 0; i < DEPTH; i++) ram_mem[i] = '0;
    build_model();
    test_reset();
    test_init();
    test_wrap_burst();
    test_stall();
    test_random_bursts();
    test_zero_len();
    test_collision();
    test_reset_mid_init();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
